// File: rtl/slatch_pkg.sv
// rtl/slatch_pkg.sv - shared types and width helper for the slatchn latch
//
// Purpose: channel-index type and the src/pointer width function shared by
// slatchn and slatch_arb.
// Ports: none (package).
// Config: SLATCHN_RR_EN (not used here; see slatchn / slatch_arb).

package slatch_pkg;

  // Largest legal channel count; ch_idx_t is sized to address all of them.
  localparam int MAX_NCH = 16;

  // Full-range channel index used inside the arbiter before narrowing to CW.
  typedef logic [3:0] ch_idx_t;

  // Width of a channel index for n channels. A single channel still gets one
  // bit so that src and the pointer never collapse to zero width.
  function automatic int cw_of(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/slatch_arb.sv
// rtl/slatch_arb.sv - single-grant arbiter for the slatchn request channels
//
// Purpose: picks at most one eligible channel per cycle. Default build is
// fixed priority (lowest index wins). With SLATCHN_RR_EN defined the search
// starts at ptr and wraps modulo NCH.
// Ports:
//   elig    [NCH-1:0] in  : channels currently allowed to write
//   ptr     [CW-1:0]  in  : round-robin start index (SLATCHN_RR_EN only)
//   gnt_vld           out : a channel was selected
//   gnt_idx [CW-1:0]  out : index of the selected channel (0 when none)
// Config: SLATCHN_RR_EN selects round-robin arbitration.

module slatch_arb
  import slatch_pkg::*;
#(
  parameter int NCH = 3,
  parameter int CW  = cw_of(NCH)
) (
  input  logic [NCH-1:0] elig,
`ifdef SLATCHN_RR_EN
  input  logic [CW-1:0]  ptr,
`endif
  output logic           gnt_vld,
  output logic [CW-1:0]  gnt_idx
);

  ch_idx_t win;

`ifdef SLATCHN_RR_EN

  // Each eligible channel is ranked by its distance from ptr going upward
  // with wrap; the smallest distance wins. ptr is always < NCH because the
  // top only ever loads it with a wrapped value.
  int best_dist;
  int dist;

  always_comb begin
    gnt_vld   = 1'b0;
    win       = '0;
    best_dist = NCH;
    dist      = 0;
    for (int i = 0; i < NCH; i++) begin
      dist = (i + NCH - int'(ptr)) % NCH;
      if (elig[i] && (dist < best_dist)) begin
        best_dist = dist;
        gnt_vld   = 1'b1;
        win       = ch_idx_t'(i);
      end
    end
  end

`else

  // Scan from the top down so the lowest eligible index is written last.
  always_comb begin
    gnt_vld = 1'b0;
    win     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_vld = 1'b1;
        win     = ch_idx_t'(i);
      end
    end
  end

`endif

  assign gnt_idx = win[CW-1:0];

endmodule

// File: rtl/slatchn.sv
// rtl/slatchn.sv - multi-channel four-phase handshake latch
//
// Purpose: NCH request channels compete to load a shared WIDTH-bit register.
// A channel is eligible while req=1 and its ack=0; one channel is granted per
// edge, which loads q, raises its ack, pulses upd and records src. ack drops
// at the first edge that samples req low, so every req pulse writes q once.
// Ports:
//   clk                  in  : clock, rising edge
//   res_n                in  : asynchronous active-low reset
//   req   [NCH-1:0]      in  : per-channel write request (level)
//   d     [NCH*WIDTH-1:0] in : channel i data at [i*WIDTH +: WIDTH]
//   q     [WIDTH-1:0]    out : latched value
//   ack   [NCH-1:0]      out : per-channel acknowledge (registered)
//   upd                  out : one-cycle pulse after q was written
//   src   [CW-1:0]       out : channel that last wrote q
// Config: define SLATCHN_RR_EN for round-robin arbitration (adds a pointer
// register); otherwise fixed priority with lowest index winning.

module slatchn
  import slatch_pkg::*;
#(
  parameter int               NCH   = 3,
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0,
  localparam int              CW    = cw_of(NCH)
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*WIDTH-1:0] d,
  output logic [WIDTH-1:0]     q,
  output logic [NCH-1:0]       ack,
  output logic                 upd,
  output logic [CW-1:0]        src
);

  logic [NCH-1:0]   elig;
  logic             gnt_vld;
  logic [CW-1:0]    gnt_idx;
  logic [NCH-1:0]   gnt_oh;
  logic [WIDTH-1:0] wr_data;
  logic [NCH-1:0]   ack_nxt;

  // A channel already acknowledged must see its req go low before it can
  // compete again, which is what makes one request equal one write.
  assign elig = req & ~ack;

`ifdef SLATCHN_RR_EN
  logic [CW-1:0] ptr;
  logic [CW-1:0] ptr_nxt;
`endif

  slatch_arb #(
    .NCH (NCH),
    .CW  (CW)
  ) u_arb (
    .elig    (elig),
`ifdef SLATCHN_RR_EN
    .ptr     (ptr),
`endif
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Decode the grant into a one-hot and select the winner's data.
  always_comb begin
    gnt_oh  = '0;
    wr_data = q;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_vld && (gnt_idx == CW'(i))) begin
        gnt_oh[i] = 1'b1;
        wr_data   = d[i*WIDTH +: WIDTH];
      end
    end
  end

  // ack survives only while req stays high; a low req clears it regardless
  // of any grant elsewhere. A granted channel always has req=1.
  assign ack_nxt = req & (ack | gnt_oh);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      q   <= INIT;
      ack <= '0;
      upd <= 1'b0;
      src <= '0;
    end else begin
      ack <= ack_nxt;
      upd <= gnt_vld;
      if (gnt_vld) begin
        q   <= wr_data;
        src <= gnt_idx;
      end
    end
  end

`ifdef SLATCHN_RR_EN
  // Pointer moves just past the winner so it drops to lowest precedence.
  always_comb begin
    ptr_nxt = ptr;
    if (gnt_vld) begin
      ptr_nxt = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_slatchn.sv
// tb/tb_slatchn.sv - directed self-checking bench for slatchn

module tb_slatchn;

  localparam int         NCH   = 3;
  localparam int         WIDTH = 8;
  localparam logic [7:0] INIT  = 8'h5A;

  logic        clk = 1'b0;
  logic        res_n;
  logic [2:0]  req;
  logic [23:0] d;
  logic [7:0]  q;
  logic [2:0]  ack;
  logic        upd;
  logic [1:0]  src;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  slatchn #(
    .NCH   (NCH),
    .WIDTH (WIDTH),
    .INIT  (INIT)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .req   (req),
    .d     (d),
    .q     (q),
    .ack   (ack),
    .upd   (upd),
    .src   (src)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
  endtask

  logic [2:0] fair_req [4];
  logic [1:0] fair_src [4];
  logic [2:0] cont_req [6];
  logic [1:0] cont_src [6];

  initial begin
    fair_req = '{3'b101, 3'b100, 3'b001, 3'b100};
    fair_src = '{2'd0, 2'd2, 2'd0, 2'd2};
    cont_req = '{3'b111, 3'b110, 3'b101, 3'b011, 3'b110, 3'b101};
`ifdef SLATCHN_RR_EN
    cont_req = '{3'b111, 3'b110, 3'b101, 3'b011, 3'b110, 3'b101};
    cont_src = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`else
    cont_req = '{3'b111, 3'b110, 3'b101, 3'b110, 3'b101, 3'b110};
    cont_src = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif

    // Reset asserted between edges takes effect immediately.
    res_n = 1'b1;
    req   = '0;
    d     = '0;
    #1 res_n = 1'b0;
    #1;
    check("rst_q",   32'(q),   32'h5A);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_upd", 32'(upd), 32'h0);
    check("rst_src", 32'(src), 32'h0);
    @(negedge clk);
    res_n = 1'b1;

    // Single request on channel 1.
    d   = {8'h00, 8'h33, 8'h00};
    req = 3'b010;
    tick();
    check("single_q",   32'(q),   32'h33);
    check("single_ack", 32'(ack), 32'h2);
    check("single_upd", 32'(upd), 32'h1);
    check("single_src", 32'(src), 32'h1);
    tick();
    check("single_upd2", 32'(upd), 32'h0);
    check("single_ack2", 32'(ack), 32'h2);
    check("single_q2",   32'(q),   32'h33);
    req = 3'b000;
    tick();
    check("single_ackclr", 32'(ack), 32'h0);

    // Fixed priority with all three requesting.
    d   = {8'd3, 8'd2, 8'd1};
    req = 3'b111;
    tick();
    check("prio0_q",   32'(q),   32'd1);
    check("prio0_src", 32'(src), 32'd0);
    check("prio0_ack", 32'(ack), 32'h1);
    req = 3'b110;
    tick();
    check("prio1_q",   32'(q),   32'd2);
    check("prio1_src", 32'(src), 32'd1);
    check("prio1_ack", 32'(ack), 32'h2);
    req = 3'b100;
    tick();
    check("prio2_q",   32'(q),   32'd3);
    check("prio2_src", 32'(src), 32'd2);
    check("prio2_ack", 32'(ack), 32'h4);
    req = 3'b000;
    tick();
    check("prio_idle_ack", 32'(ack), 32'h0);
    check("prio_idle_upd", 32'(upd), 32'h0);
    check("prio_idle_q",   32'(q),   32'd3);

    // Withdrawal: channel 2 pulses while channel 0 wins, then drops.
    d   = {8'hEE, 8'h00, 8'hA0};
    req = 3'b101;
    tick();
    check("wd_q0",   32'(q),   32'hA0);
    check("wd_ack0", 32'(ack), 32'h1);
    req = 3'b001;
    tick();
    check("wd_q1",   32'(q),   32'hA0);
    check("wd_ack1", 32'(ack), 32'h1);
    check("wd_upd1", 32'(upd), 32'h0);
    req = 3'b000;
    tick();
    check("wd_q2",   32'(q),   32'hA0);
    check("wd_ack2", 32'(ack), 32'h0);

    // Channels 0 and 2 re-request straight after each handshake.
    do_reset();
    d = {8'h30, 8'h00, 8'h10};
    for (int k = 0; k < 4; k++) begin
      req = fair_req[k];
      tick();
      check($sformatf("fair%0d_src", k), 32'(src), 32'(fair_src[k]));
      check($sformatf("fair%0d_upd", k), 32'(upd), 32'h1);
      check($sformatf("fair%0d_q", k), 32'(q), (fair_src[k] == 2'd0) ? 32'h10 : 32'h30);
    end
    req = 3'b000;
    tick();

    // Three-way contention: fixed priority starves channel 2, round-robin rotates.
    do_reset();
    d = {8'h30, 8'h20, 8'h10};
    for (int k = 0; k < 6; k++) begin
      req = cont_req[k];
      tick();
      check($sformatf("cont%0d_src", k), 32'(src), 32'(cont_src[k]));
      check($sformatf("cont%0d_upd", k), 32'(upd), 32'h1);
      check($sformatf("cont%0d_q", k), 32'(q), 32'h10 * (32'(cont_src[k]) + 32'd1));
    end
    req = 3'b000;
    tick();

    // Reset in the middle of a handshake.
    d   = {8'h00, 8'h77, 8'h00};
    req = 3'b010;
    tick();
    check("mid_ack_pre", 32'(ack), 32'h2);
    check("mid_q_pre",   32'(q),   32'h77);
    #2 res_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'h0);
    check("mid_rst_q",   32'(q),   32'h5A);
    check("mid_rst_upd", 32'(upd), 32'h0);
    check("mid_rst_src", 32'(src), 32'h0);
    @(negedge clk);
    res_n = 1'b1;
    tick();
    check("mid_regrant_ack", 32'(ack), 32'h2);
    check("mid_regrant_q",   32'(q),   32'h77);
    check("mid_regrant_upd", 32'(upd), 32'h1);
    check("mid_regrant_src", 32'(src), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
